gen_waddr_mb: RTL and testbench



---
 rtl/gen_waddr_mb.sv | 160 ++++++++++++++++
 tb/tb_gen_waddr_mb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_waddr_mb.sv
`default_nettype none
// ============================================================================
// Module   : gen_waddr_mb
// Purpose  : Multi-bank write-address generator for the line-buffer SRAM
//            array. Emits {bank, offset} write addresses for an incoming pixel
//            stream, with a runtime-selectable bank count and an optional
//            padding pre-offset. It tracks the fill level of the current bank,
//            stalls writes once the bank is full and flags overflow.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   SYS_CLK         clock (rising edge)
//   SYS_NRST        asynchronous active-low reset
//   clr_i           synchronous clear back to IDLE
//   data_sop_i      start of picture; restarts at bank 0
//   data_vld_i      input beat valid
//   wready_i        SRAM can accept a write
//   wraddr_start_i  start offset inside each bank
//   bank_limit_i    words per bank before full (0 means 2^AW)
//   pic_size_i      picture width, scales the padding pre-offset
//   padding_i       apply the padding pre-offset on sop
//   bank_last_i     index of the last bank used this picture
//   wbank_update_i  advance to the next bank
//   waddr_o         {bank, offset} write address
//   wen_o           write strobe qualifying waddr_o
//   bank_full_o     current bank reached its limit
//   ovf_o           sticky overflow (beat dropped while full)
// ============================================================================
module gen_waddr_mb #(
  parameter int AW      = 10,
  parameter int NBANK   = 3,
  parameter int BW      = 2,
  parameter int PAD_MUL = 8
) (
  input  logic             SYS_CLK,
  input  logic             SYS_NRST,
  input  logic             clr_i,
  input  logic             data_sop_i,
  input  logic             data_vld_i,
  input  logic             wready_i,
  input  logic [AW-1:0]    wraddr_start_i,
  input  logic [AW:0]      bank_limit_i,
  input  logic [5:0]       pic_size_i,
  input  logic             padding_i,
  input  logic [BW-1:0]    bank_last_i,
  input  logic             wbank_update_i,
  output logic [BW+AW-1:0] waddr_o,
  output logic             wen_o,
  output logic             bank_full_o,
  output logic             ovf_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [AW:0]   LIMIT_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [BW:0]   NBANK_W   = (BW+1)'(NBANK);
  localparam logic [BW-1:0] LAST_MAX  = BW'(NBANK - 1);
  localparam logic [AW:0]   PAD_MUL_W = (AW+1)'(PAD_MUL);

  state_t          state_q, state_d;
  logic [BW-1:0]   bank_q,  bank_d;
  logic [AW-1:0]   off_q,   off_d;
  logic [AW:0]     cnt_q,   cnt_d;
  logic            full_q,  full_d;
  logic            ovf_q,   ovf_d;

  logic [AW:0]     w_limit;
  logic [AW:0]     w_pad;
  logic [AW:0]     w_cnt_inc;
  logic [BW-1:0]   w_last;
  logic [BW-1:0]   w_bank_next;
  logic            w_beat;

  // A limit of zero encodes a completely usable bank of 2^AW words.
  assign w_limit   = (bank_limit_i == '0) ? LIMIT_MAX : bank_limit_i;
  assign w_pad     = padding_i ? ((AW+1)'(pic_size_i) * PAD_MUL_W) : '0;
  assign w_cnt_inc = cnt_q + 1'b1;

  // Out-of-range last-bank requests fold onto the highest physical bank.
  assign w_last      = ({1'b0, bank_last_i} >= NBANK_W) ? LAST_MAX : bank_last_i;
  assign w_bank_next = (bank_q >= w_last) ? '0 : bank_q + 1'b1;

  assign w_beat = data_vld_i & wready_i;
  // Control events in the same cycle pre-empt the write.
  assign wen_o  = w_beat & (state_q == FILL) & ~data_sop_i & ~wbank_update_i & ~clr_i;

  assign waddr_o     = {bank_q, off_q};
  assign bank_full_o = full_q;
  assign ovf_o       = ovf_q;

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      state_d = IDLE;
      bank_d  = '0;
      off_d   = '0;
      cnt_d   = '0;
      full_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (data_sop_i) begin
      // Padding words are counted as already used, so a large pad may
      // leave no room at all in bank 0.
      bank_d = '0;
      off_d  = wraddr_start_i + w_pad[AW-1:0];
      cnt_d  = w_pad;
      if (w_pad >= w_limit) begin
        state_d = FULL;
        full_d  = 1'b1;
      end else begin
        state_d = FILL;
        full_d  = 1'b0;
      end
    end else if (wbank_update_i && (state_q != IDLE)) begin
      bank_d  = w_bank_next;
      off_d   = wraddr_start_i;
      cnt_d   = '0;
      state_d = FILL;
      full_d  = 1'b0;
    end else if (wen_o) begin
      // Offset wraps inside the bank; it never carries into the bank bits.
      off_d = off_q + 1'b1;
      cnt_d = w_cnt_inc;
      if (w_cnt_inc == w_limit) begin
        state_d = FULL;
        full_d  = 1'b1;
      end
    end else if ((state_q == FULL) && w_beat) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      state_q <= IDLE;
      bank_q  <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gen_waddr_mb.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen_waddr_mb
// Purpose  : Self-checking bench for gen_waddr_mb. Expected write addresses
//            are queued when beats are driven and compared whenever the DUT
//            raises wen_o; status outputs are compared inline per scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gen_waddr_mb;

  localparam int AW = 10;
  localparam int BW = 2;

  logic             SYS_CLK = 1'b0;
  logic             SYS_NRST;
  logic             clr_i;
  logic             data_sop_i;
  logic             data_vld_i;
  logic             wready_i;
  logic [AW-1:0]    wraddr_start_i;
  logic [AW:0]      bank_limit_i;
  logic [5:0]       pic_size_i;
  logic             padding_i;
  logic [BW-1:0]    bank_last_i;
  logic             wbank_update_i;
  logic [BW+AW-1:0] waddr_o;
  logic             wen_o;
  logic             bank_full_o;
  logic             ovf_o;

  int checks = 0;
  int errors = 0;
  logic [BW+AW-1:0] sb[$];

  gen_waddr_mb #(.AW(AW), .NBANK(3), .BW(BW), .PAD_MUL(8)) dut (
    .SYS_CLK        (SYS_CLK),
    .SYS_NRST       (SYS_NRST),
    .clr_i          (clr_i),
    .data_sop_i     (data_sop_i),
    .data_vld_i     (data_vld_i),
    .wready_i       (wready_i),
    .wraddr_start_i (wraddr_start_i),
    .bank_limit_i   (bank_limit_i),
    .pic_size_i     (pic_size_i),
    .padding_i      (padding_i),
    .bank_last_i    (bank_last_i),
    .wbank_update_i (wbank_update_i),
    .waddr_o        (waddr_o),
    .wen_o          (wen_o),
    .bank_full_o    (bank_full_o),
    .ovf_o          (ovf_o)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  function automatic logic [BW+AW-1:0] mk(input int bank, input int off);
    mk = {bank[BW-1:0], off[AW-1:0]};
  endfunction

  // One clock: at the negedge any write strobe is matched against the
  // scoreboard, then the bench moves to 1 ns after the next rising edge.
  task automatic cyc();
    logic [BW+AW-1:0] exp_a;
    @(negedge SYS_CLK);
    if (wen_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_wen: unexpected write at waddr=%h, expected no write", waddr_o);
      end else begin
        exp_a = sb.pop_front();
        if (waddr_o !== exp_a) begin
          errors++;
          $display("FAIL sb_waddr: got %h expected %h", waddr_o, exp_a);
        end
      end
    end
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic quiet();
    clr_i = 0; data_sop_i = 0; data_vld_i = 0; wbank_update_i = 0; wready_i = 1;
  endtask

  task automatic sb_empty(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected writes never seen, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic chk(input string name, input logic [BW+AW-1:0] act, input logic [BW+AW-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic do_sop();
    data_sop_i = 1; cyc(); data_sop_i = 0;
  endtask

  task automatic do_upd();
    wbank_update_i = 1; cyc(); wbank_update_i = 0;
  endtask

  task automatic test_reset();
    SYS_NRST = 0; quiet(); data_vld_i = 1;
    wraddr_start_i = '0; bank_limit_i = '0; pic_size_i = '0; padding_i = 0; bank_last_i = 2'd2;
    #12;
    if (waddr_o !== '0 || wen_o !== 1'b0 || bank_full_o !== 1'b0 || ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: waddr=%h wen=%b full=%b ovf=%b, expected all 0", waddr_o, wen_o, bank_full_o, ovf_o);
    end
    checks++;
    @(negedge SYS_CLK); SYS_NRST = 1; data_vld_i = 0;
    @(posedge SYS_CLK); #1;
  endtask

  task automatic test_basic_fill();
    quiet(); padding_i = 0; wraddr_start_i = 10'h010; bank_limit_i = 11'd4;
    do_sop();
    data_vld_i = 1;
    for (int i = 0; i < 2; i++) begin sb.push_back(mk(0, 'h10 + i)); cyc(); end
    wready_i = 0; cyc(); wready_i = 1;            // stall: no write, no move
    chk("stall_hold", waddr_o, mk(0, 'h12));
    for (int i = 2; i < 4; i++) begin sb.push_back(mk(0, 'h10 + i)); cyc(); end
    data_vld_i = 0;
    chk("basic_full", {11'd0, bank_full_o}, 12'd1);
    chk("basic_addr_after", waddr_o, mk(0, 'h14));
    chk("basic_no_ovf", {11'd0, ovf_o}, 12'd0);
    sb_empty("basic_writes");
  endtask

  task automatic test_padding();
    quiet(); padding_i = 1; pic_size_i = 6'd5; wraddr_start_i = '0; bank_limit_i = 11'd64;
    do_sop();
    chk("pad_first_addr", waddr_o, mk(0, 'h28));
    data_vld_i = 1;
    for (int i = 0; i < 23; i++) begin sb.push_back(mk(0, 'h28 + i)); cyc(); end
    chk("pad_not_full_23", {11'd0, bank_full_o}, 12'd0);
    sb.push_back(mk(0, 'h28 + 23)); cyc();
    data_vld_i = 0;
    chk("pad_full_24", {11'd0, bank_full_o}, 12'd1);
    sb_empty("pad_writes");
    // Pad equal to the limit leaves no room: full straight from sop.
    pic_size_i = 6'd8;
    do_sop();
    chk("pad_eq_limit_full", {11'd0, bank_full_o}, 12'd1);
    data_vld_i = 1; cyc(); data_vld_i = 0;       // dropped beat, no write
    sb_empty("pad_eq_limit_nowrite");
    clr_i = 1; cyc(); clr_i = 0;
  endtask

  task automatic test_bank_rotate();
    quiet(); padding_i = 0; wraddr_start_i = 10'h100; bank_limit_i = 11'd64; bank_last_i = 2'd2;
    do_sop();
    data_vld_i = 1; sb.push_back(mk(0, 'h100)); cyc(); data_vld_i = 0;
    do_upd(); chk("rot2_b1", waddr_o, mk(1, 'h100));
    do_upd(); chk("rot2_b2", waddr_o, mk(2, 'h100));
    do_upd(); chk("rot2_b0", waddr_o, mk(0, 'h100));
    bank_last_i = 2'd3;                           // clamped to bank 2
    do_sop(); chk("rot3_b0", waddr_o, mk(0, 'h100));
    do_upd(); chk("rot3_b1", waddr_o, mk(1, 'h100));
    do_upd(); chk("rot3_b2", waddr_o, mk(2, 'h100));
    do_upd(); chk("rot3_wrap", waddr_o, mk(0, 'h100));
    sb_empty("rot_writes");
  endtask

  task automatic test_overflow();
    quiet(); padding_i = 0; wraddr_start_i = '0; bank_limit_i = 11'd2; bank_last_i = 2'd2;
    clr_i = 1; cyc(); clr_i = 0;
    data_vld_i = 1; cyc(); data_vld_i = 0;       // IDLE beat ignored
    chk("idle_no_ovf", {11'd0, ovf_o}, 12'd0);
    do_sop();
    data_vld_i = 1;
    sb.push_back(mk(0, 0)); cyc();
    sb.push_back(mk(0, 1)); cyc();
    chk("ovf_pre", {11'd0, ovf_o}, 12'd0);
    cyc(); cyc();                                 // two dropped beats in FULL
    data_vld_i = 0;
    chk("ovf_set", {11'd0, ovf_o}, 12'd1);
    chk("ovf_addr_hold", waddr_o, mk(0, 2));
    do_sop();
    chk("ovf_sticky_sop", {11'd0, ovf_o}, 12'd1);
    chk("ovf_sop_not_full", {11'd0, bank_full_o}, 12'd0);
    clr_i = 1; cyc(); clr_i = 0;
    chk("ovf_clr", {11'd0, ovf_o}, 12'd0);
    chk("clr_addr", waddr_o, 12'd0);
    sb_empty("ovf_writes");
  endtask

  task automatic test_priority();
    quiet(); padding_i = 1; pic_size_i = 6'd1; wraddr_start_i = 10'h020; bank_limit_i = 11'd64;
    do_sop();
    do_upd();
    chk("prio_setup_b1", waddr_o, mk(1, 'h20));
    data_sop_i = 1; wbank_update_i = 1; data_vld_i = 1;
    @(negedge SYS_CLK);
    chk("prio_sop_wen", {11'd0, wen_o}, 12'd0);
    @(posedge SYS_CLK); #1;
    data_sop_i = 0; wbank_update_i = 0; data_vld_i = 0;
    chk("prio_sop_wins", waddr_o, mk(0, 'h28));
    wbank_update_i = 1; data_vld_i = 1;
    @(negedge SYS_CLK);
    chk("prio_upd_wen", {11'd0, wen_o}, 12'd0);
    @(posedge SYS_CLK); #1;
    wbank_update_i = 0; data_vld_i = 0;
    chk("prio_upd_adv", waddr_o, mk(1, 'h20));
    sb_empty("prio_writes");
  endtask

  task automatic test_wrap_async_reset();
    quiet(); padding_i = 0; wraddr_start_i = 10'h3FE; bank_limit_i = '0; bank_last_i = 2'd2;
    do_sop();
    do_upd();
    data_vld_i = 1;
    sb.push_back(mk(1, 'h3FE)); cyc();
    sb.push_back(mk(1, 'h3FF)); cyc();
    sb.push_back(mk(1, 'h000)); cyc();
    chk("wrap_next", waddr_o, mk(1, 'h001));
    chk("wrap_not_full", {11'd0, bank_full_o}, 12'd0);
    sb_empty("wrap_writes");
    #2 SYS_NRST = 0;
    #1;
    checks++;
    if (waddr_o !== '0 || wen_o !== 1'b0 || bank_full_o !== 1'b0 || ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: waddr=%h wen=%b full=%b ovf=%b, expected all 0", waddr_o, wen_o, bank_full_o, ovf_o);
    end
    data_vld_i = 0;
    @(negedge SYS_CLK); SYS_NRST = 1;
    @(posedge SYS_CLK); #1;
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_padding();
    test_bank_rotate();
    test_overflow();
    test_priority();
    test_wrap_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
